issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Forwarding and hazard controller for the dual-issue Execute stage (issue A = older, issue B = younger).
- Generates the four forward-mux selects consumed by Execute.
- Tracks MEM/WB destination registers in its own shadow pipeline.
- Sequences load-use stalls, intra-bundle split issue and branch-redirect flushes by driving stall, a_flush and b_flush.

Parameters:
- XREG_AW, 5, register address width.
- FWD_W, 3, forward-select width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ia_valid / ib_valid  in  1  slot holds a live instruction in EX
- ia_rs1_addr, ia_rs2_addr, ib_rs1_addr, ib_rs2_addr  in  5  EX source registers
- ia_rs1_active, ia_rs2_active, ib_rs1_active, ib_rs2_active  in  1  operand actually read
- ia_rd_addr / ib_rd_addr  in  5  EX destination register
- ia_reg_write / ib_reg_write  in  1  EX writes rd
- ia_mem_read / ib_mem_read  in  1  EX instruction is a load
- redirect_a / redirect_b  in  1  taken branch/jump resolved in that slot this cycle
- a_forward_mux_src1, a_forward_mux_src2, b_forward_mux_src1, b_forward_mux_src2  out  3  forward selects
- stall  out  1  hold PC, IF/ID and ID/EX registers
- a_flush / b_flush  out  1  bubble the corresponding EX/MEM slot
- front_flush  out  1  kill IF/ID and ID/EX contents
- split_active  out  1  controller is in SPLIT state

Behaviour:
- Select encoding (shared, fixed): REG_DATA=0, A_FWD_MEM=1, A_FWD_WB=2, B_FWD_MEM=3, B_FWD_WB=4; values 5-7 are never driven.
- Shadow pipeline per slot: {wr, rd, ld} registered at MEM and at WB.
  - MEM load: wr = reg_write & valid & ~flush for that slot.
  - WB takes MEM every cycle.
  - rst clears all shadow entries.
- Match rule: operand active, addr != 0, shadow wr = 1, shadow rd == addr.
- Priority: B_MEM > A_MEM > B_WB > A_WB > REG_DATA (youngest first). All selects are combinational from current inputs and shadows.
- Load-use: an active operand matches a MEM entry with ld = 1.
- Intra-pair hazard: ib operand matches ia_rd_addr with ia_reg_write and ia_valid, rd != 0.
- FSM states: RUN, LU_STALL, SPLIT, SPLIT_LU.
- RUN:
  - Load-use (either slot) -> stall=1, a_flush=1, b_flush=1; next state LU_STALL.
  - Else intra-pair hazard -> stall=1, a_flush=0, b_flush=1; next state SPLIT.
  - Else stall=0, flushes 0.
- LU_STALL:
  - Load is now in WB and forwards from WB.
  - Re-evaluates like RUN, except a second load-use is impossible; intra-pair hazard still goes to SPLIT.
- SPLIT:
  - A already executed, so a_flush=1. B forwards A_FWD_MEM, stall=0; next state RUN.
  - If B has load-use on A (A was a load) -> stall=1, a_flush=1, b_flush=1; next state SPLIT_LU.
- SPLIT_LU: a_flush=1, B forwards from WB, stall=0; next state RUN.
- split_active=1 in SPLIT and SPLIT_LU.
- Redirect has top priority in every state:
  - redirect_a -> front_flush=1, b_flush=1, a_flush=0, stall=0; next state RUN.
  - redirect_b -> front_flush=1, a_flush=0 (or 1 if in SPLIT), b_flush=0; next state RUN.
  - Both asserted: redirect_a wins.
- Reset:
  - While rst=1: a_flush=b_flush=1, front_flush=0, stall=0, selects=REG_DATA, split_active=0.
  - After reset: state=RUN, shadows empty.
  - rst mid-stall aborts to RUN the next cycle.
- Latency: selects are valid the same cycle. A stall costs exactly one cycle per load-use; a split costs one cycle, two if split load-use.

Decomposition:
- Shared package holds:
  - Forward-select constants (REG_DATA…B_FWD_WB), shared with Execute.
  - FSM state encodings.
  - Shadow-entry struct {wr, rd[4:0], ld}.
- One sub-module, fwd_select: a pure priority comparator for one operand against the four shadow entries, instantiated 4 times.

Test Plan:
- A: add x5 (rs from regs); next bundle A reads x5 -> a_forward_mux_src1=1, no stall; the following cycle, re-reading x5 -> select 2.
- Bundle A writes x7 and B writes x7 (both reach MEM); next A reads x7 -> select 3 (B_MEM beats A_MEM).
- A: lw x3; next bundle B reads x3 -> one cycle with stall=1, a_flush=b_flush=1; then b_forward_mux_src1=2 (A_FWD_WB), stall=0.
- Bundle A: addi x4 / B: add x6,x4,x1 -> cycle 1: stall=1, b_flush=1, a_flush=0; cycle 2: a_flush=1, b select=1, split_active=1; then RUN.
- Bundle A: lw x4 / B uses x4 -> RUN→SPLIT→SPLIT_LU, stalls total 2 cycles, final B select=2.
- redirect_a asserted during SPLIT -> front_flush=1, b_flush=1, next state RUN; x0 as rd is never forwarded (select 0); rst held 3 cycles mid-LU_STALL -> selects 0, shadows cleared.

Source files
------------

// File: rtl/issue_hazard_ctrl_pkg.sv
// issue_hazard_ctrl_pkg: shared definitions for the dual-issue forwarding/hazard controller.
//   - forward-select codes consumed by the Execute operand muxes
//   - controller FSM state encoding
//   - shadow pipeline entry {wr, rd, ld} and the operand/entry match helper
package issue_hazard_ctrl_pkg;

    localparam int XREG_AW = 5;
    localparam int FWD_W   = 3;

    localparam logic [FWD_W-1:0] REG_DATA  = 3'd0;
    localparam logic [FWD_W-1:0] A_FWD_MEM = 3'd1;
    localparam logic [FWD_W-1:0] A_FWD_WB  = 3'd2;
    localparam logic [FWD_W-1:0] B_FWD_MEM = 3'd3;
    localparam logic [FWD_W-1:0] B_FWD_WB  = 3'd4;

    typedef enum logic [1:0] {RUN, LU_STALL, SPLIT, SPLIT_LU} state_t;

    typedef struct packed {
        logic               wr;
        logic [XREG_AW-1:0] rd;
        logic               ld;
    } shadow_t;

    // Operand hits an entry; with need_ld set the entry must also hold a load result.
    function automatic logic hit(input shadow_t e, input logic [XREG_AW-1:0] addr,
                                 input logic active, input logic need_ld);
        return active && addr != '0 && e.wr && e.rd == addr && (e.ld || !need_ld);
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_fwd_select.sv
// issue_hazard_ctrl_fwd_select: priority comparator for one source operand against the
// four shadow entries (youngest producer wins: B_MEM > A_MEM > B_WB > A_WB).
//   i_addr, i_active                     operand register and whether it is read
//   i_mem_a, i_mem_b, i_wb_a, i_wb_b     shadow entries
//   o_sel                                forward-mux select
//   o_ld                                 operand depends on a load still in MEM
module issue_hazard_ctrl_fwd_select
    import issue_hazard_ctrl_pkg::*;
(
    input  logic [XREG_AW-1:0] i_addr,
    input  logic               i_active,
    input  shadow_t            i_mem_a,
    input  shadow_t            i_mem_b,
    input  shadow_t            i_wb_a,
    input  shadow_t            i_wb_b,
    output logic [FWD_W-1:0]   o_sel,
    output logic               o_ld
);
    logic w_mem_a, w_mem_b, w_wb_a, w_wb_b;

    assign w_mem_a = hit(i_mem_a, i_addr, i_active, 1'b0);
    assign w_mem_b = hit(i_mem_b, i_addr, i_active, 1'b0);
    assign w_wb_a  = hit(i_wb_a,  i_addr, i_active, 1'b0);
    assign w_wb_b  = hit(i_wb_b,  i_addr, i_active, 1'b0);
    assign o_sel   = w_mem_b ? B_FWD_MEM : w_mem_a ? A_FWD_MEM :
                     w_wb_b  ? B_FWD_WB  : w_wb_a  ? A_FWD_WB  : REG_DATA;
    assign o_ld    = hit(i_mem_a, i_addr, i_active, 1'b1) | hit(i_mem_b, i_addr, i_active, 1'b1) |
                     hit(i_wb_a, '0, 1'b0, 1'b1) | hit(i_wb_b, '0, 1'b0, 1'b1);

endmodule

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: forwarding and hazard controller for the dual-issue Execute stage
// (slot A older, slot B younger).
//   clk, rst                          clock, synchronous active-high reset
//   i_ia_* / i_ib_*                   EX slot: valid, sources, destination, write/load flags
//   i_redirect_a / i_redirect_b       taken branch/jump resolved in that slot
//   o_{a,b}_forward_mux_src{1,2}      forward selects
//   o_stall                           hold PC, IF/ID, ID/EX
//   o_a_flush / o_b_flush             bubble the slot's EX/MEM entry
//   o_front_flush                     kill IF/ID and ID/EX
//   o_split_active                    controller in SPLIT or SPLIT_LU
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ia_valid,
    input  logic               i_ib_valid,
    input  logic [XREG_AW-1:0] i_ia_rs1_addr,
    input  logic [XREG_AW-1:0] i_ia_rs2_addr,
    input  logic [XREG_AW-1:0] i_ib_rs1_addr,
    input  logic [XREG_AW-1:0] i_ib_rs2_addr,
    input  logic               i_ia_rs1_active,
    input  logic               i_ia_rs2_active,
    input  logic               i_ib_rs1_active,
    input  logic               i_ib_rs2_active,
    input  logic [XREG_AW-1:0] i_ia_rd_addr,
    input  logic [XREG_AW-1:0] i_ib_rd_addr,
    input  logic               i_ia_reg_write,
    input  logic               i_ib_reg_write,
    input  logic               i_ia_mem_read,
    input  logic               i_ib_mem_read,
    input  logic               i_redirect_a,
    input  logic               i_redirect_b,
    output logic [FWD_W-1:0]   o_a_forward_mux_src1,
    output logic [FWD_W-1:0]   o_a_forward_mux_src2,
    output logic [FWD_W-1:0]   o_b_forward_mux_src1,
    output logic [FWD_W-1:0]   o_b_forward_mux_src2,
    output logic               o_stall,
    output logic               o_a_flush,
    output logic               o_b_flush,
    output logic               o_front_flush,
    output logic               o_split_active
);
    state_t             r_state, w_next;
    shadow_t            r_mem_a, r_mem_b, r_wb_a, r_wb_b;
    shadow_t            w_ia_ent;
    logic [XREG_AW-1:0] w_addr [4];
    logic [3:0]         w_act, w_ld;
    logic [FWD_W-1:0]   w_sel [4];
    logic               w_lu, w_b_lu, w_intra;

    assign w_addr = '{i_ia_rs1_addr, i_ia_rs2_addr, i_ib_rs1_addr, i_ib_rs2_addr};
    assign w_act  = {i_ib_rs2_active, i_ib_rs1_active, i_ia_rs2_active, i_ia_rs1_active};

    for (genvar g = 0; g < 4; g++) begin : g_op
        issue_hazard_ctrl_fwd_select u_fwd (
            .i_addr   (w_addr[g]),
            .i_active (w_act[g]),
            .i_mem_a  (r_mem_a),
            .i_mem_b  (r_mem_b),
            .i_wb_a   (r_wb_a),
            .i_wb_b   (r_wb_b),
            .o_sel    (w_sel[g]),
            .o_ld     (w_ld[g])
        );
    end

    // In SPLIT the B half of MEM is always a bubble, so a B load hit can only be on A's load.
    assign w_lu     = |w_ld;
    assign w_b_lu   = w_ld[2] | w_ld[3];
    assign w_ia_ent = '{wr: i_ia_valid & i_ia_reg_write, rd: i_ia_rd_addr, ld: i_ia_mem_read};
    assign w_intra  = hit(w_ia_ent, i_ib_rs1_addr, i_ib_rs1_active, 1'b0) |
                      hit(w_ia_ent, i_ib_rs2_addr, i_ib_rs2_active, 1'b0);

    assign o_a_forward_mux_src1 = rst ? REG_DATA : w_sel[0];
    assign o_a_forward_mux_src2 = rst ? REG_DATA : w_sel[1];
    assign o_b_forward_mux_src1 = rst ? REG_DATA : w_sel[2];
    assign o_b_forward_mux_src2 = rst ? REG_DATA : w_sel[3];
    assign o_split_active       = ~rst & (r_state == SPLIT || r_state == SPLIT_LU);

    always_comb begin
        w_next        = RUN;
        o_stall       = 1'b0;
        o_a_flush     = 1'b0;
        o_b_flush     = 1'b0;
        o_front_flush = 1'b0;
        if (rst) begin
            o_a_flush = 1'b1;
            o_b_flush = 1'b1;
        end else if (i_redirect_a) begin
            o_front_flush = 1'b1;
            o_b_flush     = 1'b1;
        end else if (i_redirect_b) begin
            o_front_flush = 1'b1;
            o_a_flush     = r_state == SPLIT;
        end else begin
            case (r_state)
                RUN, LU_STALL: begin
                    // The load that caused LU_STALL is now in WB, so only RUN can raise load-use.
                    if (r_state == RUN && w_lu) begin
                        {o_stall, o_a_flush, o_b_flush} = 3'b111;
                        w_next = LU_STALL;
                    end else if (w_intra) begin
                        {o_stall, o_b_flush} = 2'b11;
                        w_next = SPLIT;
                    end
                end
                SPLIT: begin
                    o_a_flush = 1'b1;
                    if (w_b_lu) begin
                        {o_stall, o_b_flush} = 2'b11;
                        w_next = SPLIT_LU;
                    end
                end
                default: o_a_flush = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_mem_a <= '0;
            r_mem_b <= '0;
            r_wb_a  <= '0;
            r_wb_b  <= '0;
        end else begin
            r_state <= w_next;
            r_mem_a <= '{wr: i_ia_reg_write & i_ia_valid & ~o_a_flush, rd: i_ia_rd_addr, ld: i_ia_mem_read};
            r_mem_b <= '{wr: i_ib_reg_write & i_ib_valid & ~o_b_flush, rd: i_ib_rd_addr, ld: i_ib_mem_read};
            r_wb_a  <= r_mem_a;
            r_wb_b  <= r_mem_b;
        end
    end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb_issue_hazard_ctrl: directed scenarios plus random traffic against a history-based reference model.
module tb_issue_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ia_valid, ib_valid;
    logic [4:0] ia_rs1_addr, ia_rs2_addr, ib_rs1_addr, ib_rs2_addr;
    logic       ia_rs1_active, ia_rs2_active, ib_rs1_active, ib_rs2_active;
    logic [4:0] ia_rd_addr, ib_rd_addr;
    logic       ia_reg_write, ib_reg_write, ia_mem_read, ib_mem_read;
    logic       redirect_a, redirect_b;
    logic [2:0] a_src1, a_src2, b_src1, b_src2;
    logic       stall, a_flush, b_flush, front_flush, split_active;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    issue_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .i_ia_valid(ia_valid), .i_ib_valid(ib_valid),
        .i_ia_rs1_addr(ia_rs1_addr), .i_ia_rs2_addr(ia_rs2_addr),
        .i_ib_rs1_addr(ib_rs1_addr), .i_ib_rs2_addr(ib_rs2_addr),
        .i_ia_rs1_active(ia_rs1_active), .i_ia_rs2_active(ia_rs2_active),
        .i_ib_rs1_active(ib_rs1_active), .i_ib_rs2_active(ib_rs2_active),
        .i_ia_rd_addr(ia_rd_addr), .i_ib_rd_addr(ib_rd_addr),
        .i_ia_reg_write(ia_reg_write), .i_ib_reg_write(ib_reg_write),
        .i_ia_mem_read(ia_mem_read), .i_ib_mem_read(ib_mem_read),
        .i_redirect_a(redirect_a), .i_redirect_b(redirect_b),
        .o_a_forward_mux_src1(a_src1), .o_a_forward_mux_src2(a_src2),
        .o_b_forward_mux_src1(b_src1), .o_b_forward_mux_src2(b_src2),
        .o_stall(stall), .o_a_flush(a_flush), .o_b_flush(b_flush),
        .o_front_flush(front_flush), .o_split_active(split_active)
    );

    // Reference model: what actually entered the pipeline, by age (0 = one cycle ago, 1 = two) and slot (0 = A, 1 = B).
    typedef struct {bit wr; int rd; bit ld;} prod_t;
    prod_t hist [2][2];
    bit m_a_done, m_split_lu, m_post_lu;
    bit m_lu, m_blu, m_intra;
    int e_sel [4];
    bit e_stall, e_af, e_bf, e_ff, e_split;

    function automatic int m_fwd(input logic [4:0] a, input logic act);
        if (!act || a == 5'd0) return 0;
        for (int age = 0; age < 2; age++)
            for (int s = 1; s >= 0; s--)
                if (hist[age][s].wr && hist[age][s].rd == int'(a)) return 1 + 2 * s + age;
        return 0;
    endfunction

    function automatic bit m_ldhit(input logic [4:0] a, input logic act, input int s);
        return act && a != 5'd0 && hist[0][s].wr && hist[0][s].ld && hist[0][s].rd == int'(a);
    endfunction

    task automatic model_eval();
        logic [4:0] ad [4];
        logic       ac [4];
        ad = '{ia_rs1_addr, ia_rs2_addr, ib_rs1_addr, ib_rs2_addr};
        ac = '{ia_rs1_active, ia_rs2_active, ib_rs1_active, ib_rs2_active};
        m_lu = 0; m_blu = 0; m_intra = 0;
        for (int i = 0; i < 4; i++) begin
            e_sel[i] = rst ? 0 : m_fwd(ad[i], ac[i]);
            m_lu = m_lu | m_ldhit(ad[i], ac[i], 0) | m_ldhit(ad[i], ac[i], 1);
            if (i >= 2) begin
                m_blu = m_blu | m_ldhit(ad[i], ac[i], 0);
                m_intra = m_intra | (ac[i] && ad[i] != 5'd0 && ia_valid && ia_reg_write && ad[i] == ia_rd_addr);
            end
        end
        {e_stall, e_af, e_bf, e_ff} = 4'b0000;
        if (rst) {e_af, e_bf} = 2'b11;
        else if (redirect_a) {e_ff, e_bf} = 2'b11;
        else if (redirect_b) begin e_ff = 1; e_af = m_a_done && !m_split_lu; end
        else if (m_a_done) begin
            e_af = 1;
            if (!m_split_lu && m_blu) {e_stall, e_bf} = 2'b11;
        end
        else if (m_lu && !m_post_lu) {e_stall, e_af, e_bf} = 3'b111;
        else if (m_intra) {e_stall, e_bf} = 2'b11;
        e_split = !rst && m_a_done;
    endtask

    task automatic model_commit();
        if (rst) begin
            for (int age = 0; age < 2; age++)
                for (int s = 0; s < 2; s++) hist[age][s] = '{0, 0, 0};
            {m_a_done, m_split_lu, m_post_lu} = 3'b000;
        end else begin
            for (int s = 0; s < 2; s++) hist[1][s] = hist[0][s];
            hist[0][0] = '{ia_valid && ia_reg_write && !e_af, int'(ia_rd_addr), ia_mem_read};
            hist[0][1] = '{ib_valid && ib_reg_write && !e_bf, int'(ib_rd_addr), ib_mem_read};
            if (redirect_a || redirect_b) {m_a_done, m_split_lu, m_post_lu} = 3'b000;
            else if (m_a_done) begin
                if (!m_split_lu && m_blu) m_split_lu = 1;
                else {m_a_done, m_split_lu} = 2'b00;
            end
            else if (m_lu && !m_post_lu) m_post_lu = 1;
            else if (m_intra) begin m_a_done = 1; m_post_lu = 0; end
            else m_post_lu = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_check();
        @(negedge clk);
        model_eval();
        chk("a_src1", 8'(a_src1), 8'(e_sel[0]));
        chk("a_src2", 8'(a_src2), 8'(e_sel[1]));
        chk("b_src1", 8'(b_src1), 8'(e_sel[2]));
        chk("b_src2", 8'(b_src2), 8'(e_sel[3]));
        chk("stall", 8'(stall), 8'(e_stall));
        chk("a_flush", 8'(a_flush), 8'(e_af));
        chk("b_flush", 8'(b_flush), 8'(e_bf));
        chk("front_flush", 8'(front_flush), 8'(e_ff));
        chk("split_active", 8'(split_active), 8'(e_split));
    endtask

    task automatic step_end();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        step_check();
        step_end();
    endtask

    task automatic drv_a(input logic v, input logic [4:0] r1, input logic a1, input logic [4:0] r2,
                         input logic a2, input logic [4:0] rd, input logic rw, input logic ld);
        {ia_valid, ia_rs1_addr, ia_rs1_active, ia_rs2_addr, ia_rs2_active} = {v, r1, a1, r2, a2};
        {ia_rd_addr, ia_reg_write, ia_mem_read} = {rd, rw, ld};
    endtask

    task automatic drv_b(input logic v, input logic [4:0] r1, input logic a1, input logic [4:0] r2,
                         input logic a2, input logic [4:0] rd, input logic rw, input logic ld);
        {ib_valid, ib_rs1_addr, ib_rs1_active, ib_rs2_addr, ib_rs2_active} = {v, r1, a1, r2, a2};
        {ib_rd_addr, ib_reg_write, ib_mem_read} = {rd, rw, ld};
    endtask

    task automatic idle();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; redirect_a = 0; redirect_b = 0;
        idle();
        for (int i = 0; i < 2; i++) begin
            step_check();
            chk("rst_a_flush", 8'(a_flush), 8'd1);
            chk("rst_stall", 8'(stall), 8'd0);
            step_end();
        end
        rst = 0;

        // add x5, then read x5 twice: MEM then WB forward
        drv_a(1, 0, 0, 0, 0, 5, 1, 0); cyc();
        drv_a(1, 5, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t1_mem_fwd", 8'(a_src1), 8'd1); chk("t1_no_stall", 8'(stall), 8'd0); step_end();
        step_check(); chk("t1_wb_fwd", 8'(a_src1), 8'd2); step_end();
        idle(); cyc(); cyc();

        // both slots write x7: B_MEM wins
        drv_a(1, 0, 0, 0, 0, 7, 1, 0); drv_b(1, 0, 0, 0, 0, 7, 1, 0); cyc();
        idle(); drv_a(1, 7, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t2_b_beats_a", 8'(a_src1), 8'd3); step_end();
        idle(); cyc(); cyc();

        // lw x3 then B reads x3: one stall cycle, then WB forward
        drv_a(1, 0, 0, 0, 0, 3, 1, 1); cyc();
        idle(); drv_b(1, 3, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t3_lu_stall", 8'(stall), 8'd1); chk("t3_lu_af", 8'(a_flush), 8'd1);
        chk("t3_lu_bf", 8'(b_flush), 8'd1); step_end();
        step_check(); chk("t3_after_stall", 8'(stall), 8'd0); chk("t3_wb_fwd", 8'(b_src1), 8'd2); step_end();
        idle(); cyc(); cyc();

        // addi x4 / add x6,x4,x1: split issue
        drv_a(1, 0, 0, 0, 0, 4, 1, 0); drv_b(1, 4, 1, 1, 1, 6, 1, 0);
        step_check(); chk("t4_stall", 8'(stall), 8'd1); chk("t4_bf", 8'(b_flush), 8'd1);
        chk("t4_af", 8'(a_flush), 8'd0); step_end();
        step_check(); chk("t4_split_af", 8'(a_flush), 8'd1); chk("t4_split_fwd", 8'(b_src1), 8'd1);
        chk("t4_split_active", 8'(split_active), 8'd1); chk("t4_split_stall", 8'(stall), 8'd0); step_end();
        idle();
        step_check(); chk("t4_back_run", 8'(split_active), 8'd0); step_end();
        cyc();

        // lw x4 / B uses x4: split then split load-use
        drv_a(1, 0, 0, 0, 0, 4, 1, 1); drv_b(1, 4, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t5_stall1", 8'(stall), 8'd1); step_end();
        step_check(); chk("t5_stall2", 8'(stall), 8'd1); chk("t5_split_lu_bf", 8'(b_flush), 8'd1); step_end();
        step_check(); chk("t5_stall3", 8'(stall), 8'd0); chk("t5_wb_fwd", 8'(b_src1), 8'd2);
        chk("t5_af", 8'(a_flush), 8'd1); step_end();
        idle(); cyc(); cyc();

        // redirect_a during SPLIT
        drv_a(1, 0, 0, 0, 0, 4, 1, 0); drv_b(1, 4, 1, 0, 0, 0, 0, 0); cyc();
        redirect_a = 1;
        step_check(); chk("t6_front", 8'(front_flush), 8'd1); chk("t6_bf", 8'(b_flush), 8'd1);
        chk("t6_af", 8'(a_flush), 8'd0); chk("t6_stall", 8'(stall), 8'd0); step_end();
        redirect_a = 0; idle();
        step_check(); chk("t6_run", 8'(split_active), 8'd0); step_end();
        cyc();

        // x0 as destination is never forwarded nor a pair hazard
        drv_a(1, 0, 0, 0, 0, 0, 1, 0); drv_b(1, 0, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t7_x0_no_split", 8'(stall), 8'd0); step_end();
        idle(); drv_a(1, 0, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t7_x0_no_fwd", 8'(a_src1), 8'd0); step_end();
        idle(); cyc(); cyc();

        // rst held three cycles in LU_STALL
        drv_a(1, 0, 0, 0, 0, 3, 1, 1); cyc();
        idle(); drv_b(1, 3, 1, 0, 0, 0, 0, 0);
        step_check(); chk("t8_lu", 8'(stall), 8'd1); step_end();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step_check(); chk("t8_rst_sel", 8'(b_src1), 8'd0); chk("t8_rst_stall", 8'(stall), 8'd0);
            chk("t8_rst_af", 8'(a_flush), 8'd1); step_end();
        end
        rst = 0;
        step_check(); chk("t8_cleared_sel", 8'(b_src1), 8'd0); chk("t8_cleared_stall", 8'(stall), 8'd0); step_end();

        // random traffic on a small register set so hazards are frequent
        for (int k = 0; k < 600; k++) begin
            rst = $urandom_range(0, 63) == 0;
            redirect_a = $urandom_range(0, 15) == 0;
            redirect_b = $urandom_range(0, 15) == 0;
            drv_a($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            drv_b($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
